// File: rtl/fifo_pkg.sv
// Shared types and defaults for the FIFO scheduler slice.
package fifo_pkg;

  localparam int DEPTH_DEF = 3;
  localparam int DW_DEF    = 8;

  // Operation issued on the FIFO pins in a given cycle.
  typedef enum logic [1:0] {
    OP_NONE,
    OP_WR,
    OP_RD
  } op_t;

  // Scheduler FSM: RUN issues ops, HALT is entered on a flag mismatch.
  typedef enum logic {
    RUN,
    HALT
  } state_t;

  // Opposite operation, used to alternate under write/read contention.
  function automatic op_t other_op(input op_t op);
    return (op == OP_WR) ? OP_RD : OP_WR;
  endfunction

endpackage

// File: rtl/fifo_sched_rr_arb.sv
// Round-robin arbiter: picks the first eligible requester at or after rr_ptr.
module rr_arb #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         elig,
  input  logic [$clog2(NREQ)-1:0] rr_ptr,
  output logic [$clog2(NREQ)-1:0] grant,
  output logic                    any_v
);

  localparam int IDX_W = $clog2(NREQ);

  logic [IDX_W-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest eligible index wins.
  always_comb begin
    grant = '0;
    any_v = 1'b0;
    cand  = '0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      cand = IDX_W'((int'(rr_ptr) + off) % NREQ);
      if (elig[cand]) begin
        grant = cand;
        any_v = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_sched.sv
// Shares one small byte FIFO between NREQ writers and a single reader.
// One FIFO op per cycle; occ shadows the FIFO fill level so the lagging
// full/empty flags are only used as a consistency check, never to schedule.
module fifo_sched
  import fifo_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                         clk_w,
  input  logic                         reset,
  input  logic                         en,
  input  logic [NREQ-1:0]              req_v,
  input  logic [NREQ*DW-1:0]           req_d,
  output logic [NREQ-1:0]              req_ack,
  input  logic                         rd_req,
  output logic                         rd_v,
  output logic [DW-1:0]                rd_d,
  output logic                         fifo_wre,
  output logic [DW-1:0]                fifo_wrd,
  output logic                         fifo_rde,
  input  logic [DW-1:0]                fifo_rdd,
  input  logic                         fifo_full,
  input  logic                         fifo_empty,
  output logic [$clog2(DEPTH+1)-1:0]   occ,
  output logic                         err
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] OCC_MAX  = OCC_W'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);

  state_t           state, state_n;
  op_t              last_op, last_op_n;
  op_t              op_sel;
  logic [IDX_W-1:0] rr_ptr, rr_ptr_n;
  logic [IDX_W-1:0] grant;
  logic             grant_v;
  logic [NREQ-1:0]  elig;
  logic             wr_ok, rd_ok;
  logic             idle_edge, flag_bad;

  logic [NREQ-1:0]  req_ack_n;
  logic             fifo_wre_n, fifo_rde_n;
  logic [DW-1:0]    fifo_wrd_n;
  logic [OCC_W-1:0] occ_n;
  logic             err_n;

  // The requester acked this cycle sits out one cycle so it can advance data.
  assign elig = req_v & ~req_ack;

  // Read data comes straight from the FIFO; it is only meaningful with rd_v.
  assign rd_d = fifo_rdd;

  rr_arb #(
    .NREQ (NREQ)
  ) u_arb (
    .elig   (elig),
    .rr_ptr (rr_ptr),
    .grant  (grant),
    .any_v  (grant_v)
  );

  // A read issued last cycle still has its rd_v pending, so reads are spaced.
  assign wr_ok = grant_v && (occ < OCC_MAX);
  assign rd_ok = rd_req && (occ != '0) && !fifo_rde;

  // Flags are only trusted when no op is being sampled by the FIFO this edge.
  assign idle_edge = !fifo_wre && !fifo_rde;
  assign flag_bad  = idle_edge &&
                     ((fifo_full != (occ == OCC_MAX)) || (fifo_empty != (occ == '0)));

  // Next-state and op selection; a mismatch wins over any pending op.
  always_comb begin
    state_n = state;
    op_sel  = OP_NONE;
    case (state)
      RUN: begin
        if (flag_bad) begin
          state_n = HALT;
        end else if (en) begin
          if (wr_ok && rd_ok) begin
            op_sel = other_op(last_op);
          end else if (wr_ok) begin
            op_sel = OP_WR;
          end else if (rd_ok) begin
            op_sel = OP_RD;
          end
        end
      end
      HALT: begin
        state_n = HALT;
      end
      default: begin
        state_n = HALT;
      end
    endcase
  end

  // Turn the selected op into next values for the pin registers and bookkeeping.
  always_comb begin
    req_ack_n  = '0;
    fifo_wre_n = 1'b0;
    fifo_wrd_n = '0;
    fifo_rde_n = 1'b0;
    occ_n      = occ;
    last_op_n  = last_op;
    rr_ptr_n   = rr_ptr;
    err_n      = err | ((state == RUN) && flag_bad);
    case (op_sel)
      OP_WR: begin
        req_ack_n[grant] = 1'b1;
        fifo_wre_n       = 1'b1;
        fifo_wrd_n       = req_d[int'(grant)*DW +: DW];
        occ_n            = occ + OCC_W'(1);
        last_op_n        = OP_WR;
        rr_ptr_n         = (grant == LAST_IDX) ? '0 : grant + IDX_W'(1);
      end
      OP_RD: begin
        fifo_rde_n = 1'b1;
        occ_n      = occ - OCC_W'(1);
        last_op_n  = OP_RD;
      end
      default: begin
      end
    endcase
  end

  // FSM state register; only reset leaves HALT.
  always_ff @(posedge clk_w or posedge reset) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_n;
    end
  end

  // Output and bookkeeping registers; reset aborts anything in flight.
  always_ff @(posedge clk_w or posedge reset) begin
    if (reset) begin
      last_op  <= OP_RD;
      rr_ptr   <= '0;
      req_ack  <= '0;
      fifo_wre <= 1'b0;
      fifo_wrd <= '0;
      fifo_rde <= 1'b0;
      rd_v     <= 1'b0;
      occ      <= '0;
      err      <= 1'b0;
    end else begin
      last_op  <= last_op_n;
      rr_ptr   <= rr_ptr_n;
      req_ack  <= req_ack_n;
      fifo_wre <= fifo_wre_n;
      fifo_wrd <= fifo_wrd_n;
      fifo_rde <= fifo_rde_n;
      rd_v     <= fifo_rde;
      occ      <= occ_n;
      err      <= err_n;
    end
  end

endmodule

// File: tb/tb_fifo_sched.sv
// Bench for fifo_sched: a queue-based FIFO stands in for the real one, a
// cycle-level model predicts every output, and directed phases pin the model.
module tb_fifo_sched;

  localparam int NREQ  = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 3;

  logic                 clk_w = 1'b0;
  logic                 reset;
  logic                 en;
  logic [NREQ-1:0]      req_v;
  logic [NREQ*DW-1:0]   req_d;
  logic [NREQ-1:0]      req_ack;
  logic                 rd_req;
  logic                 rd_v;
  logic [DW-1:0]        rd_d;
  logic                 fifo_wre;
  logic [DW-1:0]        fifo_wrd;
  logic                 fifo_rde;
  logic [DW-1:0]        fifo_rdd;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [1:0]           occ;
  logic                 err;

  logic                 inject_bad;
  logic                 check_on;
  int                   n_checks = 0;
  int                   n_pass = 0;

  always #5 clk_w = ~clk_w;

  fifo_sched #(
    .NREQ  (NREQ),
    .DW    (DW),
    .DEPTH (DEPTH)
  ) dut (
    .clk_w      (clk_w),
    .reset      (reset),
    .en         (en),
    .req_v      (req_v),
    .req_d      (req_d),
    .req_ack    (req_ack),
    .rd_req     (rd_req),
    .rd_v       (rd_v),
    .rd_d       (rd_d),
    .fifo_wre   (fifo_wre),
    .fifo_wrd   (fifo_wrd),
    .fifo_rde   (fifo_rde),
    .fifo_rdd   (fifo_rdd),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .occ        (occ),
    .err        (err)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
  endtask

  // Stand-in FIFO: depth 3, registered flags and read data.
  logic [7:0] fq[$];
  logic       fq_full, fq_empty;
  logic [7:0] fq_rdd;

  assign fifo_full  = fq_full;
  assign fifo_empty = inject_bad ? 1'b0 : fq_empty;
  assign fifo_rdd   = fq_rdd;

  always @(posedge clk_w or posedge reset) begin
    if (reset) begin
      fq.delete();
      fq_full  <= 1'b0;
      fq_empty <= 1'b1;
      fq_rdd   <= '0;
    end else begin
      if (fifo_rde && fq.size() > 0) fq_rdd <= fq.pop_front();
      if (fifo_wre && fq.size() < DEPTH) fq.push_back(fifo_wrd);
      fq_full  <= (fq.size() == DEPTH);
      fq_empty <= (fq.size() == 0);
    end
  end

  // Behavioural model: fill level as an integer, written bytes in a queue.
  logic [NREQ-1:0] exp_ack;
  logic            exp_wre, exp_rde, exp_rd_v, exp_err;
  logic [7:0]      exp_wrd;
  int              m_occ;
  int              m_ptr;
  bit              m_last_wr;
  bit              m_halt;
  byte unsigned    sb[$];

  always @(posedge clk_w or posedge reset) begin
    bit idle, bad, can_wr, can_rd, do_wr, do_rd;
    int g, cand;
    if (reset) begin
      exp_ack   = '0;
      exp_wre   = 1'b0;
      exp_rde   = 1'b0;
      exp_rd_v  = 1'b0;
      exp_err   = 1'b0;
      exp_wrd   = '0;
      m_occ     = 0;
      m_ptr     = 0;
      m_last_wr = 1'b0;
      m_halt    = 1'b0;
      sb.delete();
    end else begin
      idle = !exp_wre && !exp_rde;
      bad  = !m_halt && idle &&
             ((fifo_full != (m_occ == DEPTH)) || (fifo_empty != (m_occ == 0)));
      g = -1;
      for (int k = 0; k < NREQ; k++) begin
        cand = (m_ptr + k) % NREQ;
        if (g < 0 && req_v[cand] && !exp_ack[cand]) g = cand;
      end
      can_wr = (g >= 0) && (m_occ < DEPTH);
      can_rd = rd_req && (m_occ > 0) && !exp_rde;
      do_wr = 1'b0;
      do_rd = 1'b0;
      if (bad) m_halt = 1'b1;
      else if (!m_halt && en) begin
        if (can_wr && can_rd) begin
          do_wr = !m_last_wr;
          do_rd = m_last_wr;
        end else begin
          do_wr = can_wr;
          do_rd = can_rd;
        end
      end
      exp_rd_v = exp_rde;
      exp_err  = exp_err | bad;
      exp_ack  = '0;
      exp_wre  = do_wr;
      exp_rde  = do_rd;
      exp_wrd  = '0;
      if (do_wr) begin
        exp_ack[g] = 1'b1;
        exp_wrd    = req_d[g*8 +: 8];
        sb.push_back(req_d[g*8 +: 8]);
        m_ptr      = (g + 1) % NREQ;
        m_occ      = m_occ + 1;
        m_last_wr  = 1'b1;
      end
      if (do_rd) begin
        m_occ     = m_occ - 1;
        m_last_wr = 1'b0;
      end
    end
  end

  // Cycle-by-cycle comparison of every DUT output against the model.
  always @(negedge clk_w) begin
    if (check_on && !reset) begin
      checkOutput("req_ack", 32'(req_ack), 32'(exp_ack));
      checkOutput("fifo_wre", 32'(fifo_wre), 32'(exp_wre));
      checkOutput("fifo_wrd", 32'(fifo_wrd), 32'(exp_wrd));
      checkOutput("fifo_rde", 32'(fifo_rde), 32'(exp_rde));
      checkOutput("rd_v", 32'(rd_v), 32'(exp_rd_v));
      checkOutput("occ", 32'(occ), 32'(m_occ));
      checkOutput("err", 32'(err), 32'(exp_err));
      if (exp_rd_v) begin
        if (sb.size() == 0) checkOutput("rd_d_avail", 32'(0), 32'(1));
        else checkOutput("rd_d", 32'(rd_d), 32'(sb.pop_front()));
      end
    end
  end

  function automatic int qget(input int q[$], input int idx);
    return (q.size() > idx) ? q[idx] : 255;
  endfunction

  task automatic applyStimulus(input logic en_i, input logic [NREQ-1:0] req_v_i,
                               input logic rd_req_i);
    en     = en_i;
    req_v  = req_v_i;
    rd_req = rd_req_i;
  endtask

  task automatic doReset();
    @(negedge clk_w);
    reset      = 1'b1;
    inject_bad = 1'b0;
    applyStimulus(1'b0, '0, 1'b0);
    #1;
    checkOutput("reset_state",
                32'({fifo_rde, rd_v, fifo_wre, err, occ, req_ack, fifo_wrd}), 32'(0));
    @(negedge clk_w);
    reset = 1'b0;
  endtask

  initial begin
    int acks, rdvs, rdes, first_ack, second_ack, val;
    int grants[$];
    int ops[$];
    int rdata[$];
    bit found;

    reset      = 1'b0;
    check_on   = 1'b0;
    inject_bad = 1'b0;
    req_d      = '0;
    applyStimulus(1'b0, '0, 1'b0);
    doReset();
    check_on = 1'b1;

    // Single writer fills the FIFO, acked every second cycle, then stops.
    req_d[7:0] = 8'hA1;
    applyStimulus(1'b1, 4'b0001, 1'b0);
    acks = 0; first_ack = -1; second_ack = -1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk_w);
      if (req_ack[0]) begin
        acks++;
        if (first_ack < 0) first_ack = c;
        else if (second_ack < 0) second_ack = c;
      end
    end
    checkOutput("t1_ack_count", 32'(acks), 32'(3));
    checkOutput("t1_ack_spacing", 32'(second_ack - first_ack), 32'(2));
    checkOutput("t1_occ_full", 32'(occ), 32'(3));
    checkOutput("t1_fifo_full", 32'(fifo_full), 32'(1));
    checkOutput("t1_no_err", 32'(err), 32'(0));

    // Drain: one read per two cycles, data comes back as written.
    applyStimulus(1'b1, 4'b0000, 1'b1);
    rdvs = 0; val = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_w);
      if (rd_v) begin
        rdvs++;
        val = rd_d;
      end
    end
    checkOutput("t1_read_count", 32'(rdvs), 32'(3));
    checkOutput("t1_read_data", 32'(val), 32'(8'hA1));
    checkOutput("t1_occ_empty", 32'(occ), 32'(0));

    // All writers plus a reader: grants rotate and ops alternate.
    doReset();
    req_d = {8'h43, 8'h32, 8'h21, 8'h10};
    applyStimulus(1'b1, 4'b1111, 1'b1);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk_w);
      if (fifo_wre) begin
        for (int i = 0; i < NREQ; i++) if (req_ack[i]) grants.push_back(i);
        ops.push_back(1);
      end
      if (fifo_rde) ops.push_back(2);
      if (rd_v) rdata.push_back(int'(rd_d));
      for (int i = 0; i < NREQ; i++)
        if (req_ack[i]) req_d[i*8 +: 8] = req_d[i*8 +: 8] + 8'h04;
    end
    checkOutput("t2_grant_order",
                32'(qget(grants, 0) * 4096 + qget(grants, 1) * 256 +
                    qget(grants, 2) * 16 + qget(grants, 3)), 32'h0123);
    checkOutput("t2_op_order",
                32'(qget(ops, 0) * 4096 + qget(ops, 1) * 256 +
                    qget(ops, 2) * 16 + qget(ops, 3)), 32'h1212);
    checkOutput("t2_first_reads",
                32'(qget(rdata, 0) * 256 + qget(rdata, 1)), 32'h1021);

    // Reader alone on an empty FIFO: nothing happens.
    doReset();
    applyStimulus(1'b1, 4'b0000, 1'b1);
    rdes = 0; rdvs = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_w);
      if (fifo_rde) rdes++;
      if (rd_v) rdvs++;
    end
    checkOutput("t3_no_rde", 32'(rdes), 32'(0));
    checkOutput("t3_no_rd_v", 32'(rdvs), 32'(0));
    checkOutput("t3_occ", 32'(occ), 32'(0));

    // Corrupted empty flag at an idle edge halts the block until reset.
    doReset();
    applyStimulus(1'b1, 4'b0000, 1'b0);
    inject_bad = 1'b1;
    @(negedge clk_w);
    checkOutput("t4_err_set", 32'(err), 32'(1));
    checkOutput("t4_strobes_low", 32'({fifo_wre, fifo_rde, req_ack}), 32'(0));
    inject_bad = 1'b0;
    applyStimulus(1'b1, 4'b0001, 1'b1);
    acks = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_w);
      if (req_ack != '0 || fifo_wre || fifo_rde) acks++;
    end
    checkOutput("t4_halted_no_ops", 32'(acks), 32'(0));
    checkOutput("t4_err_sticky", 32'(err), 32'(1));
    doReset();
    checkOutput("t4_err_cleared", 32'(err), 32'(0));

    // Reset while a read strobe is on the pins drops the pending rd_v.
    doReset();
    req_d[7:0] = 8'h5A;
    applyStimulus(1'b1, 4'b0001, 1'b0);
    @(negedge clk_w);
    applyStimulus(1'b1, 4'b0000, 1'b1);
    found = 1'b0;
    for (int c = 0; c < 4 && !found; c++) begin
      @(negedge clk_w);
      if (fifo_rde) found = 1'b1;
    end
    checkOutput("t5_rde_seen", 32'(found), 32'(1));
    reset = 1'b1;
    applyStimulus(1'b0, 4'b0000, 1'b0);
    #1;
    checkOutput("t5_reset_outputs",
                32'({fifo_rde, rd_v, fifo_wre, err, occ, req_ack, fifo_wrd}), 32'(0));
    @(negedge clk_w);
    reset = 1'b0;
    rdvs = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_w);
      if (rd_v) rdvs++;
    end
    checkOutput("t5_no_rd_v", 32'(rdvs), 32'(0));

    // Issue enable gates new writes; re-enabling grants on the next edge.
    doReset();
    req_d[15:8] = 8'hB2;
    applyStimulus(1'b0, 4'b0010, 1'b0);
    acks = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_w);
      if (req_ack != '0) acks++;
    end
    checkOutput("t6_en_low_no_ack", 32'(acks), 32'(0));
    applyStimulus(1'b1, 4'b0010, 1'b0);
    @(negedge clk_w);
    checkOutput("t6_ack1", 32'(req_ack), 32'(4'b0010));
    checkOutput("t6_wrd", 32'(fifo_wrd), 32'(8'hB2));

    applyStimulus(1'b0, 4'b0000, 1'b0);
    repeat (3) @(negedge clk_w);
    check_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
